cpm_reg_fifo: RTL

Read-side companion to the CPM capture-enable register. It buffers words written with a single-cycle enable strobe and drains them to a downstream consumer over a valid/ready stream. It sits between CPM capture logic, which writes, and the CPM result/readout path, which reads. It provides a synchronous Clear flush and a sticky overflow flag.

---
 rtl/cpm_reg_fifo_pkg.sv | 19 +
 rtl/cpm_reg_fifo_ptr.sv | 21 ++
 rtl/cpm_reg_fifo.sv | 84 ++++++++
 3 files changed

// File: rtl/cpm_reg_fifo_pkg.sv
// Shared CPM definitions: default data width and a constant-foldable clog2.
package cpm_reg_fifo_pkg;

    localparam int unsigned CPM_DW = 8;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int unsigned cpm_clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cpm_reg_fifo_ptr.sv
// Wrapping AW-bit FIFO pointer with increment and synchronous clear.
module cpm_fifo_ptr #(
    parameter int unsigned AW = 2
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Clear,
    input  logic          Inc,
    output logic [AW-1:0] Ptr
);

    // Depth is a power of two, so natural binary rollover is the wrap.
    always_ff @(posedge Clk) begin
        if (Rst || Clear) begin
            Ptr <= '0;
        end else if (Inc) begin
            Ptr <= Ptr + AW'(1);
        end
    end

endmodule

// File: rtl/cpm_reg_fifo.sv
// CPM capture FIFO: strobe-written flop storage drained over valid/ready,
// first-word-fall-through, with flush and sticky overflow.
module cpm_reg_fifo
    import cpm_reg_fifo_pkg::*;
#(
    parameter int unsigned DW    = CPM_DW,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        Clear,
    input  logic                        WrEn,
    input  logic [DW-1:0]               DataIn,
    output logic                        Full,
    output logic                        RdValid,
    input  logic                        RdReady,
    output logic [DW-1:0]               DataOut,
    output logic [cpm_clog2(DEPTH):0]   Count,
    output logic                        Overflow
);

    localparam int unsigned AW = cpm_clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          pop_c;
    logic          push_c;
    logic          drop_c;

    assign RdValid  = (count_q != '0);
    assign Full     = (count_q == CW'(DEPTH));
    assign Count    = count_q;
    assign Overflow = overflow_q;
    assign DataOut  = RdValid ? mem[rd_ptr] : '0;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign pop_c  = RdValid && RdReady;
    assign push_c = WrEn && (!Full || pop_c);
    assign drop_c = WrEn && Full && !pop_c;

    cpm_fifo_ptr #(.AW(AW)) u_wr_ptr (
        .Clk   (Clk),
        .Rst   (Rst),
        .Clear (Clear),
        .Inc   (push_c),
        .Ptr   (wr_ptr)
    );

    cpm_fifo_ptr #(.AW(AW)) u_rd_ptr (
        .Clk   (Clk),
        .Rst   (Rst),
        .Clear (Clear),
        .Inc   (pop_c),
        .Ptr   (rd_ptr)
    );

    // Storage is never reset; writes are suppressed during reset and flush.
    always_ff @(posedge Clk) begin
        if (!Rst && !Clear && push_c) begin
            mem[wr_ptr] <= DataIn;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst || Clear) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_c && !pop_c) begin
                count_q <= count_q + CW'(1);
            end else if (pop_c && !push_c) begin
                count_q <= count_q - CW'(1);
            end
            if (drop_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule
